// File: rtl/fsm_frame_scheduler_pkg.sv
// fsm_frame_scheduler_pkg: state codes and width helper shared by the
// frame scheduler top and its round-robin arbiter.
package fsm_frame_scheduler_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FLUSH  = 2'd1;
   localparam logic [1:0] ST_SHIFT  = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fsm_frame_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req at or
// after ptr (wrapping). Ports: req, ptr in; one-hot winner, any_req out.
module rr_arbiter
   import fsm_frame_scheduler_pkg::*;
#(
   parameter int N = 4,
   localparam int PTR_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     winner,
   output logic             any_req
);

   logic [N-1:0] rot;
   logic [N-1:0] rot_win;

   // rotate so ptr sits at bit 0, take lowest set bit, rotate back
   assign rot     = N'({req, req} >> ptr);
   assign rot_win = rot & (~rot + N'(1));
   assign winner  = N'(({rot_win, rot_win} << ptr) >> N);
   assign any_req = |req;

endmodule

// File: rtl/fsm_frame_scheduler.sv
// fsm_frame_scheduler: time-shares one serial Mealy detector among N
// requesters, round-robin; shifts each captured frame MSB-first into the
// detector and reports the hit count.
// Ports: clk, rst (async active-low), req, frame_data in; gnt, busy, done,
// hit_cnt out; det_din/det_rst to detector, det_dout from detector.
// Option: define SCHED_FLUSH_EN to clear the detector before every frame.
module fsm_frame_scheduler
   import fsm_frame_scheduler_pkg::*;
#(
   parameter int N = 4,
   parameter int FRAME_W = 8,
   localparam int CNT_W = clog2(FRAME_W + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*FRAME_W-1:0] frame_data,
   output logic [N-1:0]         gnt,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     hit_cnt,
   output logic                 det_din,
   output logic                 det_rst,
   input  logic                 det_dout
);

   localparam int PTR_W = clog2(N);

   logic [1:0]         state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   nxt_ptr;
   logic [N-1:0]       winner;
   logic               any_req;
   logic [FRAME_W-1:0] shreg;
   logic [FRAME_W-1:0] cap;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               last_bit;

   rr_arbiter #(.N(N)) u_arb (
      .req     (req),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   always_comb begin
      cap = '0;
      nxt_ptr = '0;
      for (int i = 0; i < N; i++) begin
         if (winner[i]) begin
            cap = cap | frame_data[i*FRAME_W +: FRAME_W];
            nxt_ptr = (i == N - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

   assign cnt_nxt  = cnt + {{(CNT_W-1){1'b0}}, det_dout};
   assign last_bit = (bit_cnt == CNT_W'(FRAME_W - 1));
   assign busy     = (state != ST_IDLE);
   assign det_din  = (state == ST_SHIFT) & shreg[FRAME_W-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         gnt     <= '0;
         done    <= 1'b0;
         hit_cnt <= '0;
         det_rst <= 1'b1;
         ptr     <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         cnt     <= '0;
      end else begin
         done    <= 1'b0;
         det_rst <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (any_req) begin
                  gnt     <= winner;
                  shreg   <= cap;
                  bit_cnt <= '0;
                  cnt     <= '0;
                  ptr     <= nxt_ptr;
`ifdef SCHED_FLUSH_EN
                  state   <= ST_FLUSH;
                  det_rst <= 1'b1;
`else
                  state   <= ST_SHIFT;
`endif
               end
            end
            ST_FLUSH: state <= ST_SHIFT;
            ST_SHIFT: begin
               shreg   <= shreg << 1;
               bit_cnt <= bit_cnt + 1'b1;
               cnt     <= cnt_nxt;
               if (last_bit) begin
                  hit_cnt <= cnt_nxt;
                  state   <= ST_REPORT;
               end
            end
            ST_REPORT: begin
               // first cycle loads the count, second raises done
               done <= ~done;
               if (done) begin
                  state <= ST_IDLE;
                  gnt   <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_frame_scheduler.sv
// tb_fsm_frame_scheduler: random and directed stimulus against a
// frame-level reference model of the round-robin detector scheduler.
module tb_fsm_frame_scheduler;

   localparam int N = 4;
   localparam int FW = 8;
   localparam int CW = 4;
`ifdef SCHED_FLUSH_EN
   localparam int F = 1;
`else
   localparam int F = 0;
`endif
   localparam int LAST = FW + 1 + F;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*FW-1:0] frame_data;
   logic [N-1:0]  gnt;
   logic          busy;
   logic          done;
   logic [CW-1:0] hit_cnt;
   logic          det_din;
   logic          det_rst;
   logic          det_dout;
   logic [1:0]    hist;
   logic          det_mode = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   int ecnt = 0;
   int s = 0;
   int ptr_m = 0;
   int mw = 0;
   int mh = 0;
   logic act = 1'b0;
   logic rst_hold = 1'b1;
   logic [FW-1:0] mf = '0;
   int done_q[$];

   fsm_frame_scheduler #(.N(N), .FRAME_W(FW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .frame_data (frame_data),
      .gnt        (gnt),
      .busy       (busy),
      .done       (done),
      .hit_cnt    (hit_cnt),
      .det_din    (det_din),
      .det_rst    (det_rst),
      .det_dout   (det_dout)
   );

   always #5 clk = ~clk;

   // stub detector: echo, or a real overlapping "101" Mealy detector
   assign det_dout = det_mode ? (det_din && hist == 2'b10) : det_din;

   always @(posedge clk) begin
      if (det_rst) hist <= 2'b00;
      else hist <= {hist[0], det_din};
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int hits_of(input logic [FW-1:0] f, input logic mode);
      int h;
      h = 0;
      if (!mode) begin
         for (int i = 0; i < FW; i++) h += int'(f[i]);
      end else begin
         for (int i = 0; i <= FW - 3; i++)
            if (f[i+2 -: 3] == 3'b101) h++;
      end
      return h;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return (p + i) % N;
      return 0;
   endfunction

   // reference model: one frame occupies cycles s .. s+LAST after its
   // grant edge; the scheduler is free at an edge whose prior cycle was idle
   initial forever begin
      @(posedge clk);
      if (rst) begin
         rst_hold = 1'b0;
         if (act && ecnt - 1 > s + LAST) act = 1'b0;
         if (!act && |req) begin
            mw = rr_pick(req, ptr_m);
            s = ecnt;
            act = 1'b1;
            mf = frame_data[mw*FW +: FW];
            mh = hits_of(mf, det_mode);
            ptr_m = (mw + 1) % N;
         end
      end
      ecnt++;
   end

   initial forever begin
      int c;
      int rel;
      logic inframe;
      logic [N-1:0] e_gnt;
      logic e_done;
      logic e_din;
      logic e_drst;
      @(negedge clk);
      c = ecnt - 1;
      if (!rst) begin
         act = 1'b0;
         ptr_m = 0;
         rst_hold = 1'b1;
         check("rst_gnt", gnt, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_hit", hit_cnt, 0);
         check("rst_din", det_din, 0);
         check("rst_drst", det_rst, 1);
      end else begin
         rel = c - s;
         inframe = act && rel >= 0 && rel <= LAST;
         e_gnt = inframe ? (N'(1) << mw) : '0;
         e_done = inframe && rel == LAST;
         e_din = (inframe && rel >= F && rel < F + FW) ?
                 mf[FW-1-(rel-F)] : 1'b0;
         e_drst = rst_hold || (F == 1 && inframe && rel == 0);
         check("gnt", gnt, e_gnt);
         check("busy", busy, inframe);
         check("done", done, e_done);
         check("det_din", det_din, e_din);
         check("det_rst", det_rst, e_drst);
         if (e_done) check("hit_cnt", hit_cnt, mh);
         if (done) done_q.push_back(ecnt);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string tag);
      int n;
      n = 0;
      while (gnt == '0 && n < 40) begin
         step(1);
         n++;
      end
      if (gnt == '0) check(tag, 0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(2);
      rst = 1'b1;
   endtask

   task automatic random_run(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         frame_data = $urandom;
         if ($urandom_range(0, 7) == 0) req = N'($urandom);
         step(1);
      end
      req = '0;
      step(16);
   endtask

   initial begin
      rst = 1'b0;
      req = '0;
      frame_data = '0;
      step(3);
      rst = 1'b1;

      // single frame A5 from requester 0
      frame_data = {8'h00, 8'h00, 8'h00, 8'hA5};
      req = 4'b0001;
      step(1);
      req = '0;
      step(16);

      // all four requesting, round-robin from a fresh pointer
      do_reset();
      frame_data = {8'h81, 8'h0F, 8'h00, 8'hFF};
      req = 4'b1111;
      step(50);
      req = '0;
      step(16);

      // one requester held: back-to-back frames
      done_q.delete();
      frame_data = {8'h00, 8'hFF, 8'h00, 8'h00};
      req = 4'b0100;
      step(60);
      req = '0;
      step(16);
      check("done_count", done_q.size() >= 4, 1);
      for (int k = 1; k < done_q.size(); k++)
         check("done_period", done_q[k] - done_q[k-1], 11 + F);

      // reset in the 4th shift cycle
      frame_data = {4{8'hFF}};
      req = 4'b1111;
      wait_gnt("wait_first");
      step(3 + F);
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      wait_gnt("wait_regrant");
      check("rst_first_gnt", gnt, 4'b0001);
      req = '0;
      step(16);

      // request pulsed for one cycle
      frame_data = {8'h00, 8'h00, 8'h03, 8'h00};
      req = 4'b0010;
      step(1);
      req = '0;
      step(16);

      random_run(400);
      det_mode = 1'b1;
      frame_data = {8'hAD, 8'h05, 8'h40, 8'h01};
      req = 4'b1111;
      step(50);
      req = '0;
      step(16);
      random_run(400);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
